// File: rtl/lsu_mem_arbiter_if.sv
// Purpose: bundles the per-LSU request/completion lanes and the single data-memory channel.
// Latency: none, wiring only.
// Backpressure: valid/ready on every lane; master is the arbiter view, slave is the LSU/memory view.
interface lsu_mem_arbiter_if #(
    parameter int NUM_LSUS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    logic [NUM_LSUS-1:0]           lsu_read_valid;
    logic [NUM_LSUS*ADDR_BITS-1:0] lsu_read_address;
    logic [NUM_LSUS-1:0]           lsu_read_ready;
    logic [NUM_LSUS*DATA_BITS-1:0] lsu_read_data;
    logic [NUM_LSUS-1:0]           lsu_write_valid;
    logic [NUM_LSUS*ADDR_BITS-1:0] lsu_write_address;
    logic [NUM_LSUS*DATA_BITS-1:0] lsu_write_data;
    logic [NUM_LSUS-1:0]           lsu_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        input  lsu_read_valid, lsu_read_address,
        output lsu_read_ready, lsu_read_data,
        input  lsu_write_valid, lsu_write_address, lsu_write_data,
        output lsu_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output lsu_read_valid, lsu_read_address,
        input  lsu_read_ready, lsu_read_data,
        output lsu_write_valid, lsu_write_address, lsu_write_data,
        input  lsu_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Purpose: round-robin arbiter sharing one data-memory read/write channel among NUM_LSUS LSUs.
// Latency: memory request 1 cycle after grant; LSU ready pulse 1 cycle after memory ready.
// Backpressure: one outstanding request; other LSUs hold valid until granted, memory stalls via mem_*_ready.
module lsu_mem_arbiter #(
    parameter int NUM_LSUS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    lsu_mem_arbiter_if.master bus,
    output logic              busy
);
    localparam int IDX_BITS = (NUM_LSUS > 1) ? $clog2(NUM_LSUS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_LSUS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t                state;
    logic [IDX_BITS-1:0]   rr_ptr;
    logic [IDX_BITS-1:0]   grant_idx;
    logic                  op_write;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_BITS-1:0]  wdata_q;

    logic [IDX_BITS-1:0]   cand;
    logic [IDX_BITS-1:0]   pick_idx;
    logic                  pick_found;

    // Pick the first requesting LSU at or after rr_ptr, wrapping around.
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_LSUS; k++) begin
            cand = IDX_BITS'((int'(rr_ptr) + k) % NUM_LSUS);
            if (!pick_found && (bus.lsu_read_valid[cand] || bus.lsu_write_valid[cand])) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Control FSM; every output is a register updated on the state transition that needs it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            rr_ptr                <= '0;
            grant_idx             <= '0;
            op_write              <= 1'b0;
            addr_q                <= '0;
            wdata_q               <= '0;
            busy                  <= 1'b0;
            bus.lsu_read_ready    <= '0;
            bus.lsu_read_data     <= '0;
            bus.lsu_write_ready   <= '0;
            bus.mem_read_valid    <= 1'b0;
            bus.mem_read_address  <= '0;
            bus.mem_write_valid   <= 1'b0;
            bus.mem_write_address <= '0;
            bus.mem_write_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        // A write beats a read from the same LSU; the read stays pending.
                        grant_idx <= pick_idx;
                        op_write  <= bus.lsu_write_valid[pick_idx];
                        addr_q    <= bus.lsu_write_valid[pick_idx]
                                   ? bus.lsu_write_address[pick_idx*ADDR_BITS +: ADDR_BITS]
                                   : bus.lsu_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
                        wdata_q   <= bus.lsu_write_data[pick_idx*DATA_BITS +: DATA_BITS];
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_write) begin
                        bus.mem_write_valid   <= 1'b1;
                        bus.mem_write_address <= addr_q;
                        bus.mem_write_data    <= wdata_q;
                    end else begin
                        bus.mem_read_valid    <= 1'b1;
                        bus.mem_read_address  <= addr_q;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    // Only the ready matching the issued operation completes it.
                    if (op_write && bus.mem_write_ready) begin
                        bus.mem_write_valid            <= 1'b0;
                        bus.lsu_write_ready[grant_idx] <= 1'b1;
                        state                          <= RESPOND;
                    end else if (!op_write && bus.mem_read_ready) begin
                        bus.mem_read_valid                                   <= 1'b0;
                        bus.lsu_read_ready[grant_idx]                        <= 1'b1;
                        bus.lsu_read_data[grant_idx*DATA_BITS +: DATA_BITS]  <= bus.mem_read_data;
                        state                                                <= RESPOND;
                    end
                end
                RESPOND: begin
                    bus.lsu_read_ready  <= '0;
                    bus.lsu_write_ready <= '0;
                    rr_ptr              <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_BITS'(1);
                    busy                <= 1'b0;
                    state               <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Purpose: directed self-checking bench for lsu_mem_arbiter acting as the LSUs and the memory.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: memory ready is pulsed by hand after a chosen number of cycles.
module tb_lsu_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic saw_rd;

    int checks = 0;
    int errors = 0;

    lsu_mem_arbiter_if #(.NUM_LSUS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    lsu_mem_arbiter #(.NUM_LSUS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Sticky record of any memory read request.
    always @(posedge clk) begin
        if (bus.mem_read_valid === 1'b1) saw_rd = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic v, input logic [AW-1:0] a);
        bus.lsu_read_valid[i]              = v;
        bus.lsu_read_address[i*AW +: AW]   = a;
    endtask

    task automatic set_wr(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.lsu_write_valid[i]             = v;
        bus.lsu_write_address[i*AW +: AW]  = a;
        bus.lsu_write_data[i*DW +: DW]     = d;
    endtask

    // Wait for the memory request, answer it after 'delay' cycles and check the LSU completion.
    task automatic serve(input string tag, input bit is_wr, input int lane,
                         input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wdata,
                         input logic [DW-1:0] rdata, input int delay);
        int n;
        logic [N-1:0] onehot;
        n = 0;
        onehot = N'(1) << lane;
        while (((is_wr ? bus.mem_write_valid : bus.mem_read_valid) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, is_wr ? bus.mem_write_valid : bus.mem_read_valid, 1);
        check({tag, "_other_valid"}, is_wr ? bus.mem_read_valid : bus.mem_write_valid, 0);
        if (is_wr) begin
            check({tag, "_waddr"}, bus.mem_write_address, exp_addr);
            check({tag, "_wdata"}, bus.mem_write_data, exp_wdata);
        end else begin
            check({tag, "_raddr"}, bus.mem_read_address, exp_addr);
        end
        repeat (delay - 1) tick();
        check({tag, "_hold"}, is_wr ? bus.mem_write_valid : bus.mem_read_valid, 1);
        if (is_wr) begin
            bus.mem_write_ready = 1'b1;
        end else begin
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = rdata;
        end
        tick();
        bus.mem_write_ready = 1'b0;
        bus.mem_read_ready  = 1'b0;
        bus.mem_read_data   = 32'h0BAD_0BAD;
        if (is_wr) begin
            check({tag, "_wr_ready"}, bus.lsu_write_ready, onehot);
            check({tag, "_rd_ready_quiet"}, bus.lsu_read_ready, 0);
            check({tag, "_mem_wvalid_drop"}, bus.mem_write_valid, 0);
            bus.lsu_write_valid[lane] = 1'b0;
        end else begin
            check({tag, "_rd_ready"}, bus.lsu_read_ready, onehot);
            check({tag, "_wr_ready_quiet"}, bus.lsu_write_ready, 0);
            check({tag, "_rdata"}, bus.lsu_read_data[lane*DW +: DW], rdata);
            check({tag, "_mem_rvalid_drop"}, bus.mem_read_valid, 0);
            bus.lsu_read_valid[lane] = 1'b0;
        end
        tick();
        check({tag, "_pulse_end"}, {bus.lsu_read_ready, bus.lsu_write_ready}, 0);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
        int n;
        reset                 = 1'b0;
        saw_rd                = 1'b0;
        bus.lsu_read_valid    = '0;
        bus.lsu_read_address  = '0;
        bus.lsu_write_valid   = '0;
        bus.lsu_write_address = '0;
        bus.lsu_write_data    = '0;
        bus.mem_read_ready    = 1'b0;
        bus.mem_read_data     = '0;
        bus.mem_write_ready   = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_mem_valids", {bus.mem_read_valid, bus.mem_write_valid}, 0);
        check("rst_readys", {bus.lsu_read_ready, bus.lsu_write_ready}, 0);
        check("rst_rdata", bus.lsu_read_data, 0);
        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Single read from LSU1, memory answers 3 cycles after the request.
        set_rd(1, 1'b1, 8'h10);
        tick();
        check("rd1_grant_busy", busy, 1);
        check("rd1_not_yet_issued", bus.mem_read_valid, 0);
        serve("rd1", 1'b0, 1, 8'h10, 32'h0, 32'hDEAD_BEEF, 3);
        check("rd1_lanes", bus.lsu_read_data, 128'hDEAD_BEEF << 32);
        check("rd1_busy_done", busy, 0);
        tick();
        check("rd1_no_regrant", busy, 0);

        // Single write from LSU3, memory answers after 2 cycles.
        saw_rd = 1'b0;
        set_wr(3, 1'b1, 8'h22, 32'h0000_005A);
        serve("wr3", 1'b1, 3, 8'h22, 32'h0000_005A, 32'h0, 2);
        check("wr3_no_mem_read", saw_rd, 0);

        // All four read together, two rounds in strict rotation.
        for (int i = 0; i < N; i++) set_rd(i, 1'b1, AW'(8'h40 + i));
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                serve($sformatf("rr%0d_%0d", r, i), 1'b0, i, AW'(8'h40 + i), 32'h0,
                      32'h1000 + 32'(r * 16 + i), 2);
                if (r == 0) set_rd(i, 1'b1, AW'(8'h40 + i));
            end
        end

        // LSU0 read+write together plus LSU2 read: write first, then LSU2, then LSU0 read.
        set_rd(0, 1'b1, 8'h04);
        set_wr(0, 1'b1, 8'h08, 32'hA5A5_0008);
        set_rd(2, 1'b1, 8'h30);
        serve("both_wr0", 1'b1, 0, 8'h08, 32'hA5A5_0008, 32'h0, 2);
        serve("both_rd2", 1'b0, 2, 8'h30, 32'h0, 32'h2222_0030, 2);
        serve("both_rd0", 1'b0, 0, 8'h04, 32'h0, 32'h0000_0404, 2);

        // Spurious readies: in IDLE, and the wrong kind during a read wait.
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 32'h1357_9BDF;
        tick();
        bus.mem_read_ready = 1'b0;
        check("spur_idle_readys", {bus.lsu_read_ready, bus.lsu_write_ready}, 0);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_mem", {bus.mem_read_valid, bus.mem_write_valid}, 0);
        set_rd(1, 1'b1, 8'h55);
        n = 0;
        while (bus.mem_read_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("spur_rd_issue", bus.mem_read_valid, 1);
        bus.mem_write_ready = 1'b1;
        tick();
        bus.mem_write_ready = 1'b0;
        check("spur_wready_ignored", bus.mem_read_valid, 1);
        check("spur_wready_no_pulse", {bus.lsu_read_ready, bus.lsu_write_ready}, 0);
        check("spur_wready_busy", busy, 1);
        serve("spur_rd1", 1'b0, 1, 8'h55, 32'h0, 32'hCAFE_F00D, 2);

        // Reset during the third WAIT cycle of an LSU2 read, memory ready then held high.
        set_rd(2, 1'b1, 8'h66);
        n = 0;
        while (bus.mem_read_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rst_wait_issue", bus.mem_read_valid, 1);
        tick();
        tick();
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 32'h7777_7777;
        reset = 1'b0;
        #1;
        check("rst_async_mem", {bus.mem_read_valid, bus.mem_write_valid}, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_rdata", bus.lsu_read_data, 0);
        check("rst_async_readys", {bus.lsu_read_ready, bus.lsu_write_ready}, 0);
        tick();
        tick();
        check("rst_hold_readys", {bus.lsu_read_ready, bus.lsu_write_ready}, 0);
        check("rst_hold_mem", bus.mem_read_valid, 0);
        bus.mem_read_ready = 1'b0;
        set_rd(2, 1'b0, 8'h00);
        set_rd(1, 1'b1, 8'h71);
        set_rd(3, 1'b1, 8'h73);
        reset = 1'b1;
        // rr_ptr was 2 before reset; from 0 LSU1 must win over LSU3.
        serve("post_rst_rd1", 1'b0, 1, 8'h71, 32'h0, 32'h0000_0071, 2);
        serve("post_rst_rd3", 1'b0, 3, 8'h73, 32'h0, 32'h0000_0073, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one data-memory read/write channel among NUM_LSUS load-store units.
- Each LSU presents independent read and write valid/ready request pairs. The arbiter grants one request at a time using round-robin, forwards it to memory, and returns the completion handshake to the granted LSU.
- Sits between the per-thread LSUs of a core and the core's single data-memory port.

Parameters:
NUM_LSUS, 4, number of requesting LSUs (>=2)
ADDR_BITS, 8, data-memory address width
DATA_BITS, 32, data word width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
lsu_read_valid  input  NUM_LSUS  per-LSU read request
lsu_read_address  input  NUM_LSUS*ADDR_BITS  per-LSU read address
lsu_read_ready  output  NUM_LSUS  per-LSU read completion pulse
lsu_read_data  output  NUM_LSUS*DATA_BITS  per-LSU read data, valid with ready
lsu_write_valid  input  NUM_LSUS  per-LSU write request
lsu_write_address  input  NUM_LSUS*ADDR_BITS  per-LSU write address
lsu_write_data  input  NUM_LSUS*DATA_BITS  per-LSU write data
lsu_write_ready  output  NUM_LSUS  per-LSU write completion pulse
mem_read_valid  output  1  read request to memory
mem_read_address  output  ADDR_BITS  read address to memory
mem_read_ready  input  1  memory read done; mem_read_data valid
mem_read_data  input  DATA_BITS  memory read data
mem_write_valid  output  1  write request to memory
mem_write_address  output  ADDR_BITS  write address to memory
mem_write_data  output  DATA_BITS  write data to memory
mem_write_ready  input  1  memory write done
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and the rr pointer to 0.
  - All outputs go to 0, including every lsu_*_ready, every lsu_read_data lane, mem_* and busy.
  - Release is synchronous to clk.
- Registered outputs. FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Scan LSUs starting at rr_ptr, wrapping modulo NUM_LSUS. The first index i with lsu_read_valid[i] or lsu_write_valid[i] wins.
  - On the edge, latch grant_idx=i, op, address, and write data (write only).
  - If both read and write are valid for the same i, the write wins; the read is served in a later grant.
  - Move to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - Drive mem_read_valid=1 (read) or mem_write_valid=1 (write) with the latched address/data.
  - Move to WAIT. The request appears on mem_* exactly 1 cycle after the grant edge.
- WAIT:
  - Hold mem valid/address/data stable until the matching mem_*_ready=1 is sampled.
  - On that edge: clear mem valid, capture mem_read_data (read), move to RESPOND.
  - The non-matching ready is ignored.
- RESPOND:
  - lsu_*_ready[grant_idx]=1 for exactly one cycle. For reads, lsu_read_data[grant_idx] holds the captured data, held until that lane's next read completion.
  - Set rr_ptr=(grant_idx+1) mod NUM_LSUS and return to IDLE.
  - The LSU clears its valid on the edge where it samples ready. In IDLE the next cycle that LSU is therefore not re-granted the same request.
- Latency: a request granted at edge 0 with memory ready at edge k (k>=2) gives lsu ready high in the cycle after edge k. No new memory request is issued before RESPOND completes; at most 1 outstanding.
- A requester deasserting valid while not granted is simply skipped. A requester deasserting after its grant still completes; its ready pulse is issued regardless.
- mem_*_ready arriving in IDLE, ISSUE or RESPOND is ignored.
- Address/data widths pass through unchanged; no arithmetic on addresses.
- Fairness: with all LSUs continuously requesting, grants cycle 0,1,2,…,N-1,0. No LSU waits more than NUM_LSUS-1 other grants.

Test Plan:
1. Reset in cycle 3 of WAIT on a read from LSU2, memory ready held 1 afterwards -> all outputs 0 immediately, state IDLE, no lsu_read_ready pulse, rr_ptr=0.
2. Single read, LSU1 addr 0x10, memory returns 0xDEADBEEF 3 cycles after mem_read_valid -> mem_read_address=0x10, then lsu_read_ready[1] one-cycle pulse with lsu_read_data[1]=0xDEADBEEF; no other lane toggles.
3. Single write, LSU3 addr 0x22 data 0x5A, mem_write_ready after 2 cycles -> mem_write_address=0x22, mem_write_data=0x5A, then lsu_write_ready[3] one-cycle pulse; mem_read_valid never asserted.
4. All four LSUs assert reads at once and hold until served -> service order 0,1,2,3. Each LSU re-requests once served; the next round is 0,1,2,3 again.
5. LSU0 asserts read and write together (addr 0x04/0x08) -> write to 0x08 is served first, then read of 0x04 after other pending LSUs in round-robin order.
6. Spurious mem_read_ready while in IDLE, and mem_write_ready during a read WAIT -> ignored. The read completes only on mem_read_ready, and no lsu ready is generated for the spurious ready.
